// File: rtl/serial_addsub_ctrl_if.sv
// Handshake/data bundle for the bit-serial add/subtract sequencer.
// The master side supplies operands and accepts results; the slave side is the sequencer.
interface serial_addsub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, op_sub, a, b, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow, busy
  );

  modport slave (
    input  in_valid, op_sub, a, b, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, busy
  );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract: one full-adder cell stepped LSB-first over WIDTH cycles,
// with valid/ready handshakes on operands and results.
module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_addsub_ctrl_if.slave  io
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, res_q, res_d;
  logic             cy_q, cy_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s_bit, co_bit;

  assign s_bit  = a_q[0] ^ b_q[0] ^ cy_q;
  assign co_bit = (a_q[0] & b_q[0]) | (a_q[0] & cy_q) | (b_q[0] & cy_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      res_q   <= res_d;
      cy_q    <= cy_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    res_d   = res_q;
    cy_d    = cy_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        // Subtract as A + ~B + 1: invert B here and seed the carry with op_sub.
        if (io.in_valid) begin
          a_d     = io.a;
          b_d     = io.b ^ {WIDTH{io.op_sub}};
          cy_d    = io.op_sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d = {s_bit, sum_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cy_d  = co_bit;
        cnt_d = cnt_q + CW'(1);
        // Result is copied to a separate register so the output stays put outside HOLD.
        if (cnt_q == LAST) begin
          res_d   = {s_bit, sum_q[WIDTH-1:1]};
          cout_d  = co_bit;
          ovf_d   = cy_q ^ co_bit;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.busy      = (state_q == RUN);
  assign io.out_valid = (state_q == HOLD);
  assign io.result    = res_q;
  assign io.carry_out = cout_q;
  assign io.overflow  = ovf_q;
endmodule
